regfile_mp_sb: RTL
==================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-read-port integer register file with hardwired-zero r0.
//  Adds optional write-to-read bypass, selectable synchronous or combinational
//  reads, and a per-register pending-write scoreboard for hazard detection.
//  Sits in the decode stage: rd ports feed operand muxes; the write port is
//  driven by writeback; sb_set is driven by issue.
// PARAMETERS
//  ADDR_W    5   register address width; depth = 2**ADDR_W
//  DATA_W    32  register width
//  NUM_RD    2   number of read ports (1..4)
//  SYNC_READ 1   1: rd_data registered (1-cycle latency); 0: combinational
//  BYPASS    1   1: same-cycle write forwarded to a matching read
// PORTS
//  clk       in   1              rising-edge clock
//  reset     in   1              asynchronous, active-high
//  wr_en     in   1              write enable
//  wr_addr   in   ADDR_W         write address
//  wr_data   in   DATA_W         write data
//  rd_addr   in   NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rd_data   out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
//  rd_busy   out  NUM_RD         port k's register has a pending write
//  sb_set    in   1              mark sb_addr pending (instruction issued)
//  sb_addr   in   ADDR_W         destination being marked
//  busy_vec  out  2**ADDR_W      full scoreboard, bit 0 always 0
// BEHAVIOUR
//  - Reset (async): ALL registers 1..2**ADDR_W-1 := 0, scoreboard := 0,
//    registered rd_data := 0. Reset mid-write drops the write. No other state.
//  - r0: writes ignored; reads return 0; never set busy; sb_set to r0 ignored.
//  - Write: at posedge, when wr_en && wr_addr!=0, mem[wr_addr] := wr_data.
//  - SYNC_READ=1: rd_addr sampled at posedge N; rd_data valid after edge N and
//    held until next edge. BYPASS=1: write at the same edge is visible
//    (write-first). BYPASS=0: the pre-write value is returned (read-first).
//  - SYNC_READ=0: rd_data = mem[rd_addr] combinationally. BYPASS=1: if wr_en &&
//    wr_addr==rd_addr && rd_addr!=0, rd_data = wr_data in the same cycle.
//  - All read ports independent; any number may address the same register.
//  - Scoreboard: at posedge, wr_en && wr_addr!=0 clears busy[wr_addr];
//    sb_set && sb_addr!=0 sets busy[sb_addr]. Same addr both: set wins (new
//    producer issued while old one retires). sb_set on busy reg: stays 1.
//  - rd_busy[k] = busy[rd_addr_k], masked to 0 when BYPASS=1 and a clearing
//    write to that address occurs this cycle (combinational in both modes).
//  - Widths: no arithmetic; address compares are full ADDR_W wide.
// STRUCTURE
//  - regfile_pkg: RF_ADDR_W/RF_DATA_W defaults, ZERO_REG constant, typedefs
//    rf_addr_t, rf_data_t.
//  - Sub-module regfile_rd_port (one per read port via generate): address
//    register (SYNC_READ), bypass compare/mux, r0 mask, rd_busy lookup.
//  - Top holds storage array, write decode and scoreboard register.
// TESTING
//  1 Reset: write 0xDEADBEEF to r5 and r31, pulse reset -> r5, r31 read 0,
//    busy_vec==0, rd_data==0 immediately (async).
//  2 r0: wr_en, wr_addr=0, data 0xFFFFFFFF; sb_set r0 -> read r0 = 0,
//    busy_vec[0]=0.
//  3 Bypass, SYNC_READ=1: write r7=0x12345678 and read r7 same edge ->
//    BYPASS=1 returns 0x12345678 next cycle; BYPASS=0 returns old value 0.
//  4 Combinational: SYNC_READ=0,BYPASS=1, wr r9=0xA5A5A5A5, rd_addr r9 same
//    cycle -> rd_data=0xA5A5A5A5 before edge; rd_busy=0.
//  5 Scoreboard: sb_set r3 -> busy[3]=1, rd_busy=1 on port reading r3; then
//    sb_set r3 and write r3 same edge -> busy[3] stays 1; write r3 alone -> 0.
//  6 Multi-port: NUM_RD=4, all ports read r12=0x0BADF00D -> all four equal.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, types and the hardwired-zero register index for the register file.
package regfile_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  // Register index that always reads zero and can never be written or marked busy
  localparam rf_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: r0 masking, write-to-read forwarding, optional output register
// and pending-write lookup for the addressed register.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int DATA_W    = RF_DATA_W,
  parameter int DEPTH     = 2 ** ADDR_W,
  parameter int SYNC_READ = 1,
  parameter int BYPASS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rdAddr,
  input  logic [DATA_W-1:0] memData,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [DEPTH-1:0]  busyVec,
  output logic [DATA_W-1:0] rdData,
  output logic              rdBusy
);

  logic              isZero;
  logic              wrHit;
  logic [DATA_W-1:0] readVal;

  // A write landing on this port's register this cycle is forwarded when bypass is enabled;
  // the same hit hides the pending bit because that write is the one retiring it.
  always_comb begin
    isZero  = (rdAddr == ADDR_W'(ZERO_REG));
    wrHit   = (BYPASS != 0) && wrEn && (wrAddr == rdAddr) && !isZero;
    readVal = memData;
    if (isZero) begin
      readVal = '0;
    end else if (wrHit) begin
      readVal = wrData;
    end
    rdBusy = busyVec[rdAddr] & ~wrHit;
  end

  generate
    if (SYNC_READ != 0) begin : gSync
      // Capture the read value at the edge so the operand is stable for the whole next cycle
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdData <= '0;
        end else begin
          rdData <= readVal;
        end
      end
    end else begin : gComb
      assign rdData = readVal;
    end
  endgenerate

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with hardwired-zero r0 and a pending-write scoreboard.
// Writeback drives the write port, issue drives sb_set, decode reads the ports.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int DATA_W    = RF_DATA_W,
  parameter int NUM_RD    = 2,
  parameter int SYNC_READ = 1,
  parameter int BYPASS    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] memArray [DEPTH];
  logic [DEPTH-1:0]  busyReg;
  logic [DEPTH-1:0]  busyNext;
  logic              wrValid;
  logic              sbValid;

  assign wrValid  = wr_en && (wr_addr != ADDR_W'(ZERO_REG));
  assign sbValid  = sb_set && (sb_addr != ADDR_W'(ZERO_REG));
  assign busy_vec = busyReg;

  // Storage: entry 0 is cleared at reset and never written, so it always reads zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        memArray[i] <= '0;
      end
    end else if (wrValid) begin
      memArray[wr_addr] <= wr_data;
    end
  end

  // Retiring write clears its destination first so a same-cycle issue to it re-marks it busy
  always_comb begin
    busyNext = busyReg;
    if (wrValid) begin
      busyNext[wr_addr] = 1'b0;
    end
    if (sbValid) begin
      busyNext[sb_addr] = 1'b1;
    end
    busyNext[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busyReg <= '0;
    end else begin
      busyReg <= busyNext;
    end
  end

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : gPort
      logic [ADDR_W-1:0] portAddr;
      assign portAddr = rd_addr[k*ADDR_W +: ADDR_W];

      regfile_rd_port #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .SYNC_READ(SYNC_READ),
        .BYPASS   (BYPASS)
      ) uPort (
        .clk    (clk),
        .reset  (reset),
        .rdAddr (portAddr),
        .memData(memArray[portAddr]),
        .wrEn   (wr_en),
        .wrAddr (wr_addr),
        .wrData (wr_data),
        .busyVec(busyReg),
        .rdData (rd_data[k*DATA_W +: DATA_W]),
        .rdBusy (rd_busy[k])
      );
    end
  endgenerate

endmodule
